layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//   Drives one fully-connected layer through a single combinational neuron_operation datapath.
//   - Accepts an input activation vector.
//   - Reads one weight row per neuron from a synchronous weight memory.
//   - Presents weight row and activation vector to the neuron datapath.
//   - Collects each neuron_value into an output activation vector.
//   Sits between the previous layer's output buffer (or the input loader) and the next layer.
// PARAMETERS
//   BITWIDTH     16  width of one fixed-point element (same format as qmult)
//   VEC_LEN      8   elements per input activation / weight row
//   NUM_NEURONS  8   neurons in this layer (= elements in out_vec)
//   ADDR_W       3   weight-memory address width, 2**ADDR_W >= NUM_NEURONS
// PORTS
//   clk           in   1                     system clock, rising edge
//   rst           in   1                     synchronous, active-high reset
//   in_valid      in   1                     in_vec valid
//   in_ready      out  1                     block can accept in_vec
//   in_vec        in   VEC_LEN*BITWIDTH      input activations, element i at [i*BITWIDTH +: BITWIDTH]
//   w_rd_en       out  1                     weight-memory read strobe
//   w_addr        out  ADDR_W                weight row index (= neuron index)
//   w_rd_data     in   VEC_LEN*BITWIDTH      weight row, valid 1 cycle after w_rd_en
//   neuron_w      out  VEC_LEN*BITWIDTH      to neuron_operation.w
//   neuron_y      out  VEC_LEN*BITWIDTH      to neuron_operation.y_out
//   neuron_value  in   BITWIDTH              from neuron_operation.neuron_value
//   out_valid     out  1                     out_vec complete and stable
//   out_ready     in   1                     consumer accepts out_vec
//   out_vec       out  NUM_NEURONS*BITWIDTH  neuron k result at [k*BITWIDTH +: BITWIDTH]
//   busy          out  1                     state != IDLE
// BEHAVIOUR
//   States: IDLE, FETCH, EVAL, DONE. Counter k in [0, NUM_NEURONS-1].
//   Reset (any state, mid-run included), next cycle:
//     - state=IDLE, k=0, busy=0, out_valid=0, w_rd_en=0;
//     - w_addr=0, out_vec=0, y register=0.
//     - An in-flight run is abandoned with no partial out_valid.
//   IDLE:
//     - in_ready=1.
//     - On in_valid&in_ready: latch in_vec into y register, clear out_vec to 0, k=0, go to FETCH.
//   FETCH:
//     - w_rd_en=1, w_addr=k; go to EVAL.
//   EVAL:
//     - w_rd_en=0. neuron_w = w_rd_data (combinational pass-through), neuron_y = y register.
//     - At clock edge: out_vec slot k <= neuron_value.
//     - If k==NUM_NEURONS-1 go to DONE, else k<=k+1 and go to FETCH.
//   DONE:
//     - out_valid=1; out_vec and neuron_y held stable.
//     - On out_ready go to IDLE; out_valid drops next cycle.
//   in_ready=1 only in IDLE. in_valid is ignored in FETCH/EVAL/DONE; no input is queued.
//   Latency and throughput:
//     - Accept edge = cycle 0; first FETCH = cycle 1.
//     - Slot k captured at end of cycle 2k+2.
//     - out_valid first high in cycle 2*NUM_NEURONS+1.
//     - Back-to-back throughput: 2*NUM_NEURONS+2 cycles per vector with out_ready tied high.
//   Weight reads: exactly NUM_NEURONS w_rd_en pulses per run, addresses 0..NUM_NEURONS-1 ascending.
//     - w_addr holds its last value outside FETCH.
//   No arithmetic in this block; element values pass bit-exact.
//     - Saturation and rounding are owned by neuron_operation/qmult.
//   out_ready while not out_valid has no effect.
// TESTING
//   1. Assert rst 2 cycles mid-FETCH -> next cycle:
//      - all outputs 0, state IDLE, in_ready=1.
//   2. Q8.8 identity run:
//      - Stimulus: row k = 0x0100 at element k, else 0; in_vec = {1.0..8.0} (0x0100..0x0800).
//      - Expect: out_vec = in_vec.
//      - Expect: out_valid first high exactly cycle 17 after accept.
//   3. Leaky path:
//      - Stimulus: in_vec element 0 = -2.0 (0xFE00), row 0 = identity.
//      - Expect: slot 0 = qmult(0xFE00, LEAKY_RELU_SLOPE).
//      - Expect: the other slots match the scenario-2 values.
//   4. Backpressure:
//      - Stimulus: hold out_ready=0 for 10 cycles in DONE.
//      - Expect: out_valid stays 1, out_vec unchanged, in_ready=0, no w_rd_en pulses.
//      - Expect: handshake then returns to IDLE.
//   5. Back-to-back:
//      - Stimulus: in_valid held high, out_ready tied 1, two distinct vectors.
//      - Expect: second accept exactly 1 cycle after first out handshake.
//      - Expect: second out_vec correct and not mixed with the first.
//   6. Reset at k=3 in EVAL, then a new vector:
//      - Expect: no out_valid from the aborted run.
//      - Expect: new run gives w_addr 0..7, exactly 8 reads, correct out_vec.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: fetches one weight row per neuron and collects each neuron result.
// Latency: accept at cycle 0, slot k captured at end of cycle 2k+2, out_valid from cycle 2*NUM_NEURONS+1.
// Backpressure: in_ready only in IDLE (no input queueing); DONE holds out_vec stable until out_ready.
module layer_sequencer #(
    parameter int BITWIDTH    = 16,
    parameter int VEC_LEN     = 8,
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    // input activation handshake
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [VEC_LEN*BITWIDTH-1:0]     in_vec,
    // synchronous weight memory, data returns one cycle after the strobe
    output logic                            w_rd_en,
    output logic [ADDR_W-1:0]               w_addr,
    input  logic [VEC_LEN*BITWIDTH-1:0]     w_rd_data,
    // combinational neuron datapath
    output logic [VEC_LEN*BITWIDTH-1:0]     neuron_w,
    output logic [VEC_LEN*BITWIDTH-1:0]     neuron_y,
    input  logic [BITWIDTH-1:0]             neuron_value,
    // output activation handshake
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*BITWIDTH-1:0] out_vec,
    output logic                            busy
);

    localparam int VEC_W = VEC_LEN * BITWIDTH;
    localparam int OUT_W = NUM_NEURONS * BITWIDTH;

    // index of the final neuron; reaching it in EVAL ends the run
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [VEC_W-1:0]    y_q, y_d;
    logic [OUT_W-1:0]    out_q, out_d;

    // State register; reset abandons any in-flight run and clears all held data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            y_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            y_q     <= y_d;
            out_q   <= out_d;
        end
    end

    // Next-state and handshake decode; one FETCH/EVAL pair per neuron.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        y_d       = y_q;
        out_d     = out_q;
        in_ready  = 1'b0;
        w_rd_en   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_d     = in_vec;
                    out_d   = '0;
                    k_d     = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // row k is addressed now and arrives on w_rd_data during EVAL
                w_rd_en = 1'b1;
                state_d = S_EVAL;
            end

            S_EVAL: begin
                out_d[k_q*BITWIDTH +: BITWIDTH] = neuron_value;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // k only changes on the EVAL->FETCH step or at accept, so it doubles as the
    // read address and naturally holds its last value outside FETCH.
    assign w_addr   = k_q;

    // Pure pass-through: all arithmetic lives in the neuron datapath.
    assign neuron_w = w_rd_data;
    assign neuron_y = y_q;
    assign out_vec  = out_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a synchronous weight-memory model and a Q8.8 neuron model.
// Latency: checks the accept-to-out_valid distance and back-to-back accept spacing.
// Backpressure: holds out_ready low in DONE and verifies the held outputs.
module tb_layer_sequencer;

    localparam int BW = 16;
    localparam int VL = 8;
    localparam int NN = 8;
    localparam int AW = 3;
    localparam int LEAKY_RELU_SLOPE = 32;   // 0.125 in Q8.8

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [VL*BW-1:0] in_vec;
    logic             w_rd_en;
    logic [AW-1:0]    w_addr;
    logic [VL*BW-1:0] w_rd_data = '0;
    logic [VL*BW-1:0] neuron_w;
    logic [VL*BW-1:0] neuron_y;
    logic [BW-1:0]    neuron_value;
    logic             out_valid;
    logic             out_ready;
    logic [NN*BW-1:0] out_vec;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    layer_sequencer #(.BITWIDTH(BW), .VEC_LEN(VL), .NUM_NEURONS(NN), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
        .neuron_w(neuron_w), .neuron_y(neuron_y), .neuron_value(neuron_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // weight memory: row k = 1.0 at element k (identity)
    logic [VL*BW-1:0] wmem [NN];
    logic             rd_pend   = 1'b0;
    logic [AW-1:0]    addr_pend = '0;
    logic [AW-1:0]    rd_log [128];
    int               rd_total  = 0;

    // capture the read request mid-cycle, answer it on the following edge
    always @(negedge clk) begin
        rd_pend   <= w_rd_en;
        addr_pend <= w_addr;
        if (w_rd_en) begin
            rd_log[rd_total % 128] <= w_addr;
            rd_total               <= rd_total + 1;
        end
    end

    always @(posedge clk) begin
        if (rd_pend) w_rd_data <= wmem[addr_pend];
    end

    // Q8.8 dot product with saturation and leaky ReLU
    function automatic logic [BW-1:0] neuron_fn(input logic [VL*BW-1:0] w, input logic [VL*BW-1:0] y);
        int acc;
        int p;
        acc = 0;
        for (int i = 0; i < VL; i++) begin
            p   = int'($signed(w[i*BW +: BW])) * int'($signed(y[i*BW +: BW]));
            acc = acc + (p >>> 8);
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        if (acc < 0)      acc = (acc * LEAKY_RELU_SLOPE) >>> 8;
        return BW'(acc);
    endfunction

    always_comb neuron_value = neuron_fn(neuron_w, neuron_y);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present a vector and return in cycle 1 (first FETCH) after the accept edge
    task automatic send(input logic [VL*BW-1:0] v);
        int n;
        in_vec   = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_timeout", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
    endtask

    // called in cycle 1; returns the cycle index where out_valid is first seen
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_addrs(input string tag, input int base);
        check({tag, "_reads"}, 128'(rd_total - base), 128'(NN));
        for (int i = 0; i < NN; i++)
            check({tag, "_addr"}, 128'(rd_log[(base + i) % 128]), 128'(i));
    endtask

    logic [VL*BW-1:0] va, vb, vb_exp, vc, vd, ve, vf, vg, held;
    int cyc, base, c, c_hs, c_acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        for (int k = 0; k < NN; k++) begin
            wmem[k] = '0;
            wmem[k][k*BW +: BW] = 16'h0100;
        end
        for (int i = 0; i < VL; i++) begin
            va[i*BW +: BW] = 16'((i + 1) * 256);          // 1.0 .. 8.0
            vc[i*BW +: BW] = 16'((8 - i) * 256);          // 8.0 .. 1.0
            vd[i*BW +: BW] = 16'(16'h0010 * (i + 1));
            ve[i*BW +: BW] = 16'(16'h0300 + 16'h0011 * i);
            vf[i*BW +: BW] = 16'(16'h1234 + 16'h0101 * i);
            vg[i*BW +: BW] = 16'(16'h0A05 + 16'h0303 * i);
        end
        vb = va;     vb[15:0]     = 16'hFE00;             // -2.0
        vb_exp = va; vb_exp[15:0] = 16'hFFC0;             // -2.0 * 0.125

        tick(); tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_vec", 128'(out_vec), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        rst = 1'b0;
        tick();

        // reset for 2 cycles in FETCH
        send(va);
        check("t1_in_fetch", 128'(w_rd_en), 128'(1));
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("t1_busy", 128'(busy), 128'(0));
        check("t1_out_valid", 128'(out_valid), 128'(0));
        check("t1_w_rd_en", 128'(w_rd_en), 128'(0));
        check("t1_w_addr", 128'(w_addr), 128'(0));
        check("t1_out_vec", 128'(out_vec), 128'(0));
        check("t1_neuron_y", 128'(neuron_y), 128'(0));
        check("t1_in_ready", 128'(in_ready), 128'(1));
        tick();

        // identity run
        base = rd_total;
        send(va);
        wait_done(cyc);
        check("t2_latency", 128'(cyc), 128'(17));
        check("t2_out_vec", 128'(out_vec), 128'(va));
        check_addrs("t2", base);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_drop_valid", 128'(out_valid), 128'(0));
        check("t2_idle", 128'(busy), 128'(0));

        // leaky path on slot 0
        send(vb);
        wait_done(cyc);
        check("t3_out_vec", 128'(out_vec), 128'(vb_exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // backpressure in DONE, with an ignored input offered meanwhile
        send(vc);
        wait_done(cyc);
        held = out_vec;
        check("t4_out_vec", 128'(held), 128'(vc));
        base = rd_total;
        in_vec = vd; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 128'(out_valid), 128'(1));
            check("t4_hold_vec", 128'(out_vec), 128'(vc));
            check("t4_in_ready", 128'(in_ready), 128'(0));
        end
        check("t4_no_reads", 128'(rd_total - base), 128'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_back_idle", 128'(busy), 128'(0));
        check("t4_in_ready_idle", 128'(in_ready), 128'(1));

        // back-to-back with out_ready tied high
        out_ready = 1'b1;
        send(vd);
        in_vec = ve; in_valid = 1'b1;
        c = 1; c_hs = -1; c_acc = -1;
        while (c_acc < 0 && c < 100) begin
            if (out_valid && c_hs < 0) begin
                c_hs = c;
                check("t5_first_vec", 128'(out_vec), 128'(vd));
            end
            if (in_ready && c_hs >= 0) c_acc = c;
            tick();
            c++;
        end
        in_vec = vf;
        in_valid = 1'b0;
        check("t5_first_done", 128'(c_hs), 128'(17));
        check("t5_accept_gap", 128'(c_acc - c_hs), 128'(1));
        wait_done(cyc);
        check("t5_second_lat", 128'(cyc), 128'(17));
        check("t5_second_vec", 128'(out_vec), 128'(ve));
        tick();
        out_ready = 1'b0;

        // reset at k=3 in EVAL, then a fresh run
        send(vf);
        for (int i = 0; i < 7; i++) tick();               // cycle 8 = EVAL k=3
        check("t6_eval_k3", 128'({w_rd_en, w_addr}), 128'({1'b0, 3'd3}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_w_addr", 128'(w_addr), 128'(0));
        check("t6_out_vec", 128'(out_vec), 128'(0));
        for (int i = 0; i < 3; i++) begin
            check("t6_no_valid", 128'(out_valid), 128'(0));
            tick();
        end
        base = rd_total;
        send(vg);
        wait_done(cyc);
        check("t6_latency", 128'(cyc), 128'(17));
        check("t6_out_vec_new", 128'(out_vec), 128'(vg));
        check_addrs("t6", base);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_idle", 128'(busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
